sixteen_to_one_demux_deser: RTL and testbench

- Receive-side counterpart of the team's 16:1 bit mux.
- Takes a single-bit stream and steers each accepted bit into one of 16 lane positions.
- Lane choice comes from an explicit select (addressed mode) or an internal lane counter (sequential mode).
- When all lanes have been written, presents the assembled 16-bit word on a valid/ready output handshake, then starts the next frame.

---
 rtl/demux_pkg.sv | 16 +
 rtl/demux_lane_decoder.sv | 20 ++
 rtl/sixteen_to_one_demux_deser.sv | 140 ++++++++++++++
 tb/tb_sixteen_to_one_demux_deser.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// demux_pkg: shared types and constants for the serial-to-lane
// demux deserializer.
package demux_pkg;

  localparam int LANES_DEF = 16;

  localparam logic MODE_ADDR = 1'b0;
  localparam logic MODE_SEQ  = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    FILL = 2'b01,
    HOLD = 2'b10
  } demux_state_e;

endpackage

// File: rtl/demux_lane_decoder.sv
// demux_lane_decoder: select-to-one-hot lane write enable,
// gated by the transfer strobe.
module demux_lane_decoder
  import demux_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int SEL_W = $clog2(LANES)
) (
  input  logic [SEL_W-1:0] sel_i,
  input  logic             stb_i,
  output logic [LANES-1:0] we_o
);

  // One-hot enable for the addressed lane, all-zero without strobe
  always_comb begin
    we_o = '0;
    if (stb_i) we_o[sel_i] = 1'b1;
  end

endmodule

// File: rtl/sixteen_to_one_demux_deser.sv
// sixteen_to_one_demux_deser: serial bit stream to LANES-wide word.
// Optional DEMUX_DUP_ERR_EN adds the dup_err duplicate-write flag.
module sixteen_to_one_demux_deser
  import demux_pkg::*;
#(
  parameter  int LANES = LANES_DEF,
  localparam int SEL_W = $clog2(LANES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic [SEL_W-1:0] sel,
  input  logic             seq_mode,
  output logic [LANES-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy
`ifdef DEMUX_DUP_ERR_EN
  ,
  output logic             dup_err
`endif
);

  demux_state_e     state_q, state_d;
  logic [LANES-1:0] dout_q, dout_d;
  logic [LANES-1:0] mask_q, mask_d;
  logic [SEL_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;

  logic             xfer;
  logic [SEL_W-1:0] lane;
  logic [LANES-1:0] we;

  assign xfer = din_valid & (state_q == FILL);
  assign lane = (mode_q == MODE_SEQ) ? cnt_q : sel;

  demux_lane_decoder #(
    .LANES (LANES),
    .SEL_W (SEL_W)
  ) u_dec (
    .sel_i (lane),
    .stb_i (xfer),
    .we_o  (we)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: frame ends on a full mask, restarts on handshake
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = FILL;
      FILL:    if (&mask_d) state_d = HOLD;
      HOLD:    if (dout_ready) state_d = FILL;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the registered state
  always_comb begin
    din_ready  = 1'b0;
    dout_valid = 1'b0;
    busy       = 1'b0;
    unique case (state_q)
      FILL: begin
        din_ready = 1'b1;
        busy      = 1'b1;
      end
      HOLD: begin
        dout_valid = 1'b1;
        busy       = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath next state: lane writes, mask, counter, mode
  always_comb begin
    dout_d = dout_q;
    mask_d = mask_q;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    unique case (state_q)
      IDLE: mode_d = seq_mode;
      FILL: begin
        dout_d = (dout_q & ~we) | ({LANES{din}} & we);
        mask_d = mask_q | we;
        if (xfer && mode_q == MODE_SEQ)
          cnt_d = cnt_q + SEL_W'(1);
      end
      HOLD: begin
        if (dout_ready) begin
          dout_d = '0;
          mask_d = '0;
          cnt_d  = '0;
          mode_d = seq_mode;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_q <= '0;
      mask_q <= '0;
      cnt_q  <= '0;
      mode_q <= MODE_ADDR;
    end else begin
      dout_q <= dout_d;
      mask_q <= mask_d;
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
    end
  end

  assign dout = dout_q;

`ifdef DEMUX_DUP_ERR_EN
  logic dup_q, dup_d;

  assign dup_d = xfer & (mode_q == MODE_ADDR) & (|(we & mask_q));

  // One-cycle flag after an addressed write to an already-written lane
  always_ff @(posedge clk) begin
    if (!rst_n) dup_q <= 1'b0;
    else        dup_q <= dup_d;
  end

  assign dup_err = dup_q;
`endif

endmodule

// File: tb/tb_sixteen_to_one_demux_deser.sv
// tb_sixteen_to_one_demux_deser: scoreboard bench with a behavioural
// frame model; build with DEMUX_DUP_ERR_EN to cover dup_err.
module tb_sixteen_to_one_demux_deser;

  localparam int M_IDLE = 0;
  localparam int M_FILL = 1;
  localparam int M_HOLD = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        din;
  logic        din_valid;
  logic        din_ready;
  logic [3:0]  sel;
  logic        seq_mode;
  logic [15:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        busy;
`ifdef DEMUX_DUP_ERR_EN
  logic        dup_err;
`endif

  sixteen_to_one_demux_deser #(.LANES(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .sel        (sel),
    .seq_mode   (seq_mode),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy)
`ifdef DEMUX_DUP_ERR_EN
    ,
    .dup_err    (dup_err)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  bit rnd_rdy = 1'b0;
  int cyc_cnt = 0;

  // Reference model: a frame is a set of written lanes plus a word
  int        m_st = M_IDLE;
  bit [15:0] m_dout = '0;
  bit        written [16];
  int        nwr = 0;
  int        m_cnt = 0;
  bit        m_mode = 1'b0;
  bit        m_dup = 1'b0;

  bit [15:0] exp_q[$];
  int        pop_cyc[$];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: wait bound expired at cycle %0d", nm, cyc_cnt);
  endtask

  task automatic new_frame(input bit mode);
    m_dout = '0;
    foreach (written[i]) written[i] = 1'b0;
    nwr = 0;
    m_cnt = 0;
    m_mode = mode;
  endtask

  always @(posedge clk) begin : model
    int lane;
    cyc_cnt++;
    m_dup = 1'b0;
    if (!rst_n) begin
      m_st = M_IDLE;
      new_frame(1'b0);
      exp_q.delete();
    end else if (m_st == M_IDLE) begin
      new_frame(seq_mode);
      m_st = M_FILL;
    end else if (m_st == M_FILL) begin
      if (din_valid) begin
        lane = m_mode ? m_cnt : int'(sel);
        if (written[lane]) begin
          if (!m_mode) m_dup = 1'b1;
        end else begin
          written[lane] = 1'b1;
          nwr++;
        end
        m_dout[lane] = din;
        m_cnt = (m_cnt + 1) % 16;
        if (nwr == 16) begin
          m_st = M_HOLD;
          exp_q.push_back(m_dout);
        end
      end
    end else begin
      if (dout_ready) begin
        new_frame(seq_mode);
        m_st = M_FILL;
      end
    end
  end

  // Monitor: per-cycle handshake checks plus scoreboard on output
  always @(negedge clk) begin
    if (chk_en) begin
      check("din_ready", 32'(din_ready), 32'(m_st == M_FILL));
      check("busy", 32'(busy), 32'(m_st != M_IDLE));
      check("dout_valid", 32'(dout_valid), 32'(m_st == M_HOLD));
      check("dout", 32'(dout), 32'(m_dout));
`ifdef DEMUX_DUP_ERR_EN
      check("dup_err", 32'(dup_err), 32'(m_dup));
`endif
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_avail", 32'(exp_q.size()), 32'd1);
        end else begin
          check("sb_word", 32'(dout), 32'(exp_q.pop_front()));
          pop_cyc.push_back(cyc_cnt);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
    if (rnd_rdy) dout_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_st(input int st, input string nm);
    int n = 0;
    while (m_st != st && n < 200) begin
      cyc();
      n++;
    end
    if (m_st != st) timeout(nm);
  endtask

  task automatic send(input bit b, input int s);
    din_valid = 1'b1;
    din = b;
    sel = 4'(s);
    wait_st(M_FILL, "send_wait");
    cyc();
  endtask

  task automatic send_word(input bit [15:0] w);
    for (int i = 0; i < 16; i++) send(w[i], 0);
  endtask

  initial begin
    bit [15:0] w;
    int k;
    rst_n = 1'b0;
    din = 1'b0;
    din_valid = 1'b0;
    sel = '0;
    seq_mode = 1'b1;
    dout_ready = 1'b0;
    for (int i = 0; i < 16; i++) written[i] = 1'b0;
    cyc();
    chk_en = 1'b1;
    cyc();
    rst_n = 1'b1;

    // Partial sequential frame discarded by reset
    for (int i = 0; i < 5; i++) send(1'b1, 0);
    din_valid = 1'b0;
    rst_n = 1'b0;
    cyc();
    check("rst_dout", 32'(dout), 32'h0);
    check("rst_valid", 32'(dout_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;

    // Sequential frame 0xA5C3
    dout_ready = 1'b1;
    send_word(16'hA5C3);
    check("seq_valid", 32'(dout_valid), 32'h1);
    check("seq_word", 32'(dout), 32'hA5C3);
    din_valid = 1'b0;
    cyc();
    check("seq_ready_after", 32'(din_ready), 32'h1);

    // Back-to-back sequential frames, constant valid/ready
    send_word(16'h0001);
    send_word(16'h8000);
    seq_mode = 1'b0;
    din_valid = 1'b0;
    wait_st(M_FILL, "b2b_drain");
    if (pop_cyc.size() >= 2)
      check("b2b_spacing",
            32'(pop_cyc[pop_cyc.size()-1] - pop_cyc[pop_cyc.size()-2]),
            32'd17);
    else
      check("b2b_pops", 32'(pop_cyc.size()), 32'd2);

    // Addressed descending with gaps, held under backpressure
    dout_ready = 1'b0;
    for (int s = 15; s >= 0; s--) begin
      send(1'(s & 1), s);
      din_valid = 1'b0;
      cyc();
    end
    din_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("hold_word", 32'(dout), 32'hAAAA);
      check("hold_ready", 32'(din_ready), 32'h0);
      cyc();
    end
    din_valid = 1'b0;
    dout_ready = 1'b1;
    wait_st(M_FILL, "addr_drain");

    // Addressed overwrite of lane 3
    dout_ready = 1'b0;
    send(1'b1, 3);
    send(1'b0, 3);
    for (int l = 0; l < 16; l++) if (l != 3) send(1'b1, l);
    din_valid = 1'b0;
    check("ovw_word", 32'(dout), 32'hFFF7);
    dout_ready = 1'b1;
    wait_st(M_FILL, "ovw_drain");

    // Mode flip mid-frame: frame stays addressed, next is sequential
    w = 16'($urandom());
    for (int l = 0; l < 8; l++) send(w[l], l);
    seq_mode = 1'b1;
    for (int l = 8; l < 16; l++) send(w[l], 15 - (l - 8) - 0);
    din_valid = 1'b0;
    wait_st(M_FILL, "mode_drain");
    w = 16'($urandom());
    send_word(w);
    din_valid = 1'b0;
    check("mode_seq_word", 32'(dout), 32'(w));

    // Randomized frames with random gaps, modes and backpressure
    rnd_rdy = 1'b1;
    for (int f = 0; f < 12; f++) begin
      seq_mode = 1'($urandom_range(0, 1));
      wait_st(M_FILL, "rnd_start");
      k = 0;
      while (m_st != M_HOLD && k < 2000) begin
        din_valid = 1'($urandom_range(0, 1));
        din = 1'($urandom_range(0, 1));
        sel = 4'($urandom_range(0, 15));
        cyc();
        k++;
      end
      if (m_st != M_HOLD) timeout("rnd_frame");
      din_valid = 1'b0;
    end
    rnd_rdy = 1'b0;
    dout_ready = 1'b1;
    wait_st(M_FILL, "final_drain");
    cyc();
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
